csub32_seq: RTL and testbench

- Multi-cycle 32-bit subtractor: D = A - B - BI.
- Computed as A + ~B + ~BI, one 4-bit lookahead slice per clock, LSB slice first.
- Accepts operands with a start/done handshake and holds the result plus status flags until the next operation.
- Sits beside the 32-bit lookahead adder in the datapath as its subtract-side counterpart, trading latency for a single 4-bit slice of logic.

---
 rtl/csub32_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_csub32_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/csub32_seq.sv
// csub32_seq: multi-cycle subtractor, d = a - b - bi.
// The operation is carried out as a + ~b + ~bi. One SLICE-bit lookahead
// slice is processed per clock, least significant slice first, and the
// inter-slice carry is held in a register. Operands are latched when an
// operation is accepted. d/bo/zero/ovf hold their values until the next
// operation completes.
module csub32_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             zero,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int MSB    = WIDTH - 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // FSM-derived control strobes
    logic load_op;     // accept a new operation this edge
    logic step_en;     // process one slice this edge
    logic finish_en;   // last slice: publish the result this edge

    // Latched operands; nb_reg holds the already-inverted subtrahend
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] nb_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;

    // Partial result, one entry per slice
    logic [SLICE-1:0] part_reg [NSLICE];

    // Published result and flags
    logic [WIDTH-1:0] d_reg;
    logic             bo_reg;
    logic             zero_reg;
    logic             ovf_reg;

    // Slice views of the latched operands
    logic [SLICE-1:0] a_sl  [NSLICE];
    logic [SLICE-1:0] nb_sl [NSLICE];

    // Current slice operands and lookahead results
    logic [SLICE-1:0] op_a;
    logic [SLICE-1:0] op_b;
    logic [SLICE-1:0] gen_s;
    logic [SLICE-1:0] prop_s;
    logic [SLICE:0]   cy;
    logic [SLICE-1:0] sum_sl;
    logic             cout;

    // Full result as it will look after the current slice is stored
    logic [WIDTH-1:0] d_full;
    logic             zero_next;
    logic             ovf_next;

    genvar gi;

    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slice_view
            assign a_sl[gi]  = a_reg[gi*SLICE +: SLICE];
            assign nb_sl[gi] = nb_reg[gi*SLICE +: SLICE];
        end
    endgenerate

    assign op_a   = a_sl[cnt_reg];
    assign op_b   = nb_sl[cnt_reg];
    assign gen_s  = op_a & op_b;
    assign prop_s = op_a ^ op_b;

    // Slice lookahead: every carry is a flat sum of generate terms
    // qualified by the propagate chain, plus the incoming carry term
    always_comb begin
        logic term;
        logic c_acc;
        cy    = '0;
        term  = 1'b0;
        c_acc = 1'b0;
        cy[0] = carry_reg;
        for (int i = 0; i < SLICE; i++) begin
            term = carry_reg;
            for (int k = 0; k <= i; k++) begin
                term = term & prop_s[k];
            end
            c_acc = term;
            for (int j = 0; j <= i; j++) begin
                term = gen_s[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & prop_s[k];
                end
                c_acc = c_acc | term;
            end
            cy[i+1] = c_acc;
        end
    end

    assign sum_sl = prop_s ^ cy[SLICE-1:0];
    assign cout   = cy[SLICE];

    // Splice the slice being computed into the stored partial result
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_full
            assign d_full[gi*SLICE +: SLICE] =
                (cnt_reg == CW'(gi)) ? sum_sl : part_reg[gi];
        end
    endgenerate

    assign zero_next = (d_full == '0);
    // a and b differ in sign exactly when a's MSB equals the inverted b MSB
    assign ovf_next  = (a_reg[MSB] == nb_reg[MSB]) && (d_full[MSB] != a_reg[MSB]);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and control strobes; DONE accepts start just like IDLE
    always_comb begin
        state_next = state_reg;
        load_op    = 1'b0;
        step_en    = 1'b0;
        finish_en  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    load_op    = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                step_en = 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    finish_en  = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    load_op    = 1'b1;
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture on accept; later input changes are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg  <= '0;
            nb_reg <= '0;
        end else if (load_op) begin
            a_reg  <= a;
            nb_reg <= ~b;
        end
    end

    // Slice counter and inter-slice carry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
        end else if (load_op) begin
            cnt_reg   <= '0;
            carry_reg <= ~bi;
        end else if (step_en) begin
            cnt_reg   <= finish_en ? '0 : cnt_reg + 1'b1;
            carry_reg <= cout;
        end
    end

    // Partial result storage, one register per slice
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_part
            // Capture this slice's sum when the counter points at it
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    part_reg[gi] <= '0;
                end else if (step_en && (cnt_reg == CW'(gi))) begin
                    part_reg[gi] <= sum_sl;
                end
            end
        end
    endgenerate

    // Result and flags update only on the completion edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_reg    <= '0;
            bo_reg   <= 1'b0;
            zero_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (finish_en) begin
            d_reg    <= d_full;
            bo_reg   <= ~cout;
            zero_reg <= zero_next;
            ovf_reg  <= ovf_next;
        end
    end

    assign busy = (state_reg == S_RUN);
    assign done = (state_reg == S_DONE);
    assign d    = d_reg;
    assign bo   = bo_reg;
    assign zero = zero_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_csub32_seq.sv
// Testbench for csub32_seq: directed cases plus randomized operations,
// each checked against a plain-arithmetic reference model.
module tb_csub32_seq;

    localparam int NS = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bi;
    logic        busy;
    logic        done;
    logic [31:0] d;
    logic        bo;
    logic        zero;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;

    csub32_seq #(.WIDTH(32), .SLICE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .bi    (bi),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bo    (bo),
        .zero  (zero),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, zero, bo, d} from unsigned 33-bit arithmetic
    function automatic logic [34:0] ref_sub(input logic [31:0] x, input logic [31:0] y, input logic z);
        logic [32:0] t;
        logic [31:0] r;
        logic        v;
        t = {1'b0, x} - {1'b0, y} - {32'd0, z};
        r = t[31:0];
        v = (x[31] != y[31]) && (r[31] != x[31]);
        return {v, (r == 32'd0), t[32], r};
    endfunction

    task automatic check_res(input string tag, input logic [31:0] x, input logic [31:0] y, input logic z);
        logic [34:0] e;
        e = ref_sub(x, y, z);
        check({tag, "_d"},    d,    e[31:0]);
        check({tag, "_bo"},   {31'd0, bo},   {31'd0, e[32]});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, e[33]});
        check({tag, "_ovf"},  {31'd0, ovf},  {31'd0, e[34]});
        $display("op %s a=%h b=%h bi=%0d -> d=%h bo=%0d zero=%0d ovf=%0d",
                 tag, x, y, z, d, bo, zero, ovf);
    endtask

    // Called at a negedge: present operands with start, pass the accept
    // edge, then scramble the inputs so latching is exercised
    task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic z);
        a = x; b = y; bi = z; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; bi = 1'($urandom_range(1));
    endtask

    // Count edges until done is seen, with a bound
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, "_timeout"}, {31'd0, done}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y, input logic z);
        int lat;
        launch(x, y, z);
        wait_done(tag, lat);
        check({tag, "_lat"}, 32'(lat), 32'(NS));
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        check_res(tag, x, y, z);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;
        int cyc;
        int last_done;
        int ndone;
        logic [34:0] e1;

        reset = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_d",    d,             32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Directed cases
        run_op("basic",    32'd5,        32'd3,        1'b0);
        run_op("borrow",   32'd3,        32'd5,        1'b0);
        run_op("ovf_neg",  32'h80000000, 32'h00000001, 1'b0);
        run_op("ovf_pos",  32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op("zero",     32'h12345678, 32'h12345678, 1'b0);
        run_op("zero_bi",  32'h12345678, 32'h12345678, 1'b1);
        run_op("all_ones", 32'hFFFFFFFF, 32'h00000000, 1'b1);

        // Handshake: start during RUN is ignored, start in DONE is accepted
        e1 = ref_sub(32'hCAFEBABE, 32'h0BADF00D, 1'b1);
        launch(32'hCAFEBABE, 32'h0BADF00D, 1'b1);
        cyc = 0;
        repeat (2) begin
            @(posedge clk); @(negedge clk); cyc++;
        end
        start = 1'b1; a = 32'h11111111; b = 32'h22222222; bi = 1'b0;
        @(posedge clk); @(negedge clk); cyc++;
        start = 1'b0; a = 32'h33333333; b = 32'h44444444;
        check("hs_busy_ign", {31'd0, busy}, 32'd1);
        wait_done("hs1", lat);
        check("hs1_lat", 32'(cyc + lat), 32'(NS));
        check_res("hs1", 32'hCAFEBABE, 32'h0BADF00D, 1'b1);
        launch(32'h00000010, 32'h00000020, 1'b1);
        check("hs2_accept_busy", {31'd0, busy}, 32'd1);
        check("hs2_accept_done", {31'd0, done}, 32'd0);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
        end
        check("hs2_hold_d", d, e1[31:0]);
        check("hs2_hold_bo", {31'd0, bo}, {31'd0, e1[32]});
        wait_done("hs2", lat);
        check("hs2_lat", 32'(lat + 3), 32'(NS));
        check_res("hs2", 32'h00000010, 32'h00000020, 1'b1);
        @(posedge clk); @(negedge clk);
        check("hs2_no_extra", {31'd0, done}, 32'd0);

        // Reset asserted between edges in the 4th RUN cycle
        launch(32'h00000001, 32'h00000002, 1'b0);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_d",    d,             32'd0);
        check("mrst_bo",   {31'd0, bo},   32'd0);
        check("mrst_zero", {31'd0, zero}, 32'd0);
        check("mrst_ovf",  {31'd0, ovf},  32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mrst_idle", {31'd0, busy}, 32'd0);
        run_op("post_rst", 32'h00010000, 32'h00000001, 1'b0);

        // Back-to-back: start held high gives one result every NS+1 clocks
        a = 32'h00000064; b = 32'h00000007; bi = 1'b1; start = 1'b1;
        cyc = 0; ndone = 0; last_done = -1;
        while (ndone < 3 && cyc < 100) begin
            @(posedge clk); @(negedge clk); cyc++;
            if (done) begin
                if (last_done >= 0) begin
                    check("b2b_gap", 32'(cyc - last_done), 32'(NS + 1));
                end
                last_done = cyc;
                ndone++;
                check("b2b_d", d, 32'h0000005C);
                if (ndone == 3) start = 1'b0;
            end
        end
        check("b2b_count", 32'(ndone), 32'd3);
        @(posedge clk); @(negedge clk);
        check("b2b_idle", {31'd0, busy}, 32'd0);

        // Randomized operations with edge-biased operands
        for (int i = 0; i < 30; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            logic        z;
            x = $urandom; y = $urandom; z = 1'($urandom_range(1));
            case ($urandom_range(4))
                0: y = x;
                1: x = {x[31], 31'd0};
                2: y = 32'hFFFFFFFF;
                default: ;
            endcase
            run_op("rand", x, y, z);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
